uart_rx_status: RTL and testbench



---
 rtl/uart_status_pkg.sv | 39 +++
 rtl/uart_rx_status_if.sv | 33 +++
 rtl/uart_rx_byte.sv | 84 ++++++++
 rtl/uart_rx_status.sv | 156 +++++++++++++++
 tb/tb_uart_rx_status.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_status_pkg.sv
// Shared constants and types for the status telemetry UART receiver.
package uart_status_pkg;

  localparam int CLK_FREQ_HZ   = 100_000_000;
  localparam int BAUD_RATE_BPS = 9600;

  localparam logic [7:0] SYNC_BYTE = 8'hFF;
  localparam int PAYLOAD_LEN = 7;

  // Position of each payload byte after the sync byte.
  typedef enum logic [2:0] {
    IDX_STATE = 3'd0,
    IDX_CHOUR = 3'd1,
    IDX_CMIN  = 3'd2,
    IDX_CSEC  = 3'd3,
    IDX_WHOUR = 3'd4,
    IDX_WMIN  = 3'd5,
    IDX_WSEC  = 3'd6
  } field_idx_e;

  typedef enum logic [1:0] {
    BYTE_IDLE  = 2'd0,
    BYTE_START = 2'd1,
    BYTE_DATA  = 2'd2,
    BYTE_STOP  = 2'd3
  } byte_state_e;

  typedef enum logic {
    PKT_HUNT    = 1'b0,
    PKT_COLLECT = 1'b1
  } pkt_state_e;

  // The state field is 3 bits wide, every time field 6 bits; the rest must be zero.
  function automatic logic upper_bits_ok(input logic [2:0] idx, input logic [7:0] b);
    if (idx == 3'(IDX_STATE)) return (b[7:3] == 5'd0);
    return (b[7:6] == 2'd0);
  endfunction

endpackage

// File: rtl/uart_rx_status_if.sv
// Decoded status fields, event pulses and FSM debug state of uart_rx_status.
interface uart_rx_status_if;
  import uart_status_pkg::*;

  // There is no backpressure: pkt_valid, frame_err and pkt_err are single-cycle
  // pulses (valid with an implied always-ready sink); the field registers only
  // change in the cycle pkt_valid is high and hold otherwise.
  logic [2:0]  state;
  logic [5:0]  current_hour;
  logic [5:0]  current_min;
  logic [5:0]  current_sec;
  logic [5:0]  working_hour;
  logic [5:0]  working_min;
  logic [5:0]  working_sec;
  logic        pkt_valid;
  logic        frame_err;
  logic        pkt_err;
  byte_state_e byte_state;
  pkt_state_e  pkt_state;

  modport master (
    output state, current_hour, current_min, current_sec,
    output working_hour, working_min, working_sec,
    output pkt_valid, frame_err, pkt_err, byte_state, pkt_state
  );

  modport slave (
    input state, current_hour, current_min, current_sec,
    input working_hour, working_min, working_sec,
    input pkt_valid, frame_err, pkt_err, byte_state, pkt_state
  );

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte deserialiser: 2-flop synchroniser plus IDLE/START/DATA/STOP FSM.
module uart_rx_byte
  import uart_status_pkg::*;
#(
  parameter int DIVISOR = 10416
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        frame_err,
  output byte_state_e fsm_state
);

  localparam int CW = $clog2(DIVISOR);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIVISOR / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIVISOR - 1);

  logic [1:0]    sync_q;
  logic          rx_s;
  byte_state_e   cur_st, nxt_st;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic          half_tick, full_tick;

  assign rx_s      = sync_q[1];
  assign half_tick = (cnt == HALF_M1);
  assign full_tick = (cnt == FULL_M1);
  assign fsm_state = cur_st;

  // Bring the asynchronous line into the clock domain; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};
  end

  // Byte FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_st <= BYTE_IDLE;
    else        cur_st <= nxt_st;
  end

  // Byte FSM next state: start bit is confirmed at its middle, data and stop at theirs.
  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      BYTE_IDLE:  if (!rx_s) nxt_st = BYTE_START;
      BYTE_START: if (half_tick) nxt_st = rx_s ? BYTE_IDLE : BYTE_DATA;
      BYTE_DATA:  if (full_tick && (bit_idx == 3'd7)) nxt_st = BYTE_STOP;
      BYTE_STOP:  if (full_tick) nxt_st = BYTE_IDLE;
      default:    nxt_st = BYTE_IDLE;
    endcase
  end

  // Bit timer, bit index, shift register and result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      bit_idx    <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // The timer restarts on every state change and every data bit, so it never wraps.
      if ((cur_st == BYTE_IDLE) || (cur_st != nxt_st) || ((cur_st == BYTE_DATA) && full_tick))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (cur_st == BYTE_START)
        bit_idx <= '0;
      else if ((cur_st == BYTE_DATA) && full_tick) begin
        byte_data[bit_idx] <= rx_s;
        bit_idx            <= bit_idx + 1'b1;
      end

      // Leaving STOP at mid stop bit lets a back-to-back start edge be seen in IDLE.
      byte_valid <= (cur_st == BYTE_STOP) && full_tick && rx_s;
      frame_err  <= (cur_st == BYTE_STOP) && full_tick && !rx_s;
    end
  end

endmodule

// File: rtl/uart_rx_status.sv
// Status telemetry receiver: frames 0xFF + 7 payload bytes into field registers.
// Optional build macro STATUS_RANGE_CHECK_EN adds an hour/minute/second range
// check at packet completion.
module uart_rx_status
  import uart_status_pkg::*;
#(
  parameter int CLK_FREQ  = CLK_FREQ_HZ,
  parameter int BAUD_RATE = BAUD_RATE_BPS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  uart_rx_status_if.master st
);

  localparam int DIVISOR = CLK_FREQ / BAUD_RATE;

  logic        byte_valid, byte_ferr;
  logic [7:0]  byte_data;
  byte_state_e byte_st;

  pkt_state_e  pkt_st, pkt_nxt;
  logic [2:0]  idx;
  logic        store, complete, err, idx_clear, range_ok;

  logic [2:0]  sh_state;
  logic [5:0]  sh_ch, sh_cm, sh_cs, sh_wh, sh_wm;

  logic [2:0]  r_state;
  logic [5:0]  r_ch, r_cm, r_cs, r_wh, r_wm, r_ws;
  logic        r_valid, r_perr;

  uart_rx_byte #(.DIVISOR(DIVISOR)) u_byte (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (byte_ferr),
    .fsm_state  (byte_st)
  );

`ifdef STATUS_RANGE_CHECK_EN
  // Hours below 24, minutes and seconds below 60; working_sec is still on the bus.
  assign range_ok = (sh_ch < 6'd24) && (sh_cm < 6'd60) && (sh_cs < 6'd60) &&
                    (sh_wh < 6'd24) && (sh_wm < 6'd60) && (byte_data[5:0] < 6'd60);
`else
  assign range_ok = 1'b1;
`endif

  // Packet FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pkt_st <= PKT_HUNT;
    else        pkt_st <= pkt_nxt;
  end

  // Packet FSM next state and datapath controls.
  always_comb begin
    pkt_nxt   = pkt_st;
    store     = 1'b0;
    complete  = 1'b0;
    err       = 1'b0;
    idx_clear = 1'b0;
    case (pkt_st)
      PKT_HUNT: begin
        if (byte_valid && (byte_data == SYNC_BYTE)) begin
          pkt_nxt   = PKT_COLLECT;
          idx_clear = 1'b1;
        end
      end
      PKT_COLLECT: begin
        if (byte_ferr) begin
          err     = 1'b1;
          pkt_nxt = PKT_HUNT;
        end else if (byte_valid) begin
          if (byte_data == SYNC_BYTE) begin
            // Payload can never be 0xFF, so this is a new packet start.
            err       = 1'b1;
            idx_clear = 1'b1;
          end else if (!upper_bits_ok(idx, byte_data)) begin
            err     = 1'b1;
            pkt_nxt = PKT_HUNT;
          end else if (idx == 3'(IDX_WSEC)) begin
            pkt_nxt  = PKT_HUNT;
            complete = range_ok;
            err      = !range_ok;
          end else begin
            store = 1'b1;
          end
        end
      end
      default: pkt_nxt = PKT_HUNT;
    endcase
  end

  // Shadow capture, output latch and event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      sh_state <= '0;
      sh_ch    <= '0;
      sh_cm    <= '0;
      sh_cs    <= '0;
      sh_wh    <= '0;
      sh_wm    <= '0;
      r_state  <= '0;
      r_ch     <= '0;
      r_cm     <= '0;
      r_cs     <= '0;
      r_wh     <= '0;
      r_wm     <= '0;
      r_ws     <= '0;
      r_valid  <= 1'b0;
      r_perr   <= 1'b0;
    end else begin
      r_valid <= complete;
      r_perr  <= err;
      if (idx_clear)  idx <= '0;
      else if (store) idx <= idx + 1'b1;
      if (store) begin
        case (idx)
          3'(IDX_STATE): sh_state <= byte_data[2:0];
          3'(IDX_CHOUR): sh_ch    <= byte_data[5:0];
          3'(IDX_CMIN):  sh_cm    <= byte_data[5:0];
          3'(IDX_CSEC):  sh_cs    <= byte_data[5:0];
          3'(IDX_WHOUR): sh_wh    <= byte_data[5:0];
          3'(IDX_WMIN):  sh_wm    <= byte_data[5:0];
          default:       ;
        endcase
      end
      if (complete) begin
        r_state <= sh_state;
        r_ch    <= sh_ch;
        r_cm    <= sh_cm;
        r_cs    <= sh_cs;
        r_wh    <= sh_wh;
        r_wm    <= sh_wm;
        r_ws    <= byte_data[5:0];
      end
    end
  end

  assign st.state        = r_state;
  assign st.current_hour = r_ch;
  assign st.current_min  = r_cm;
  assign st.current_sec  = r_cs;
  assign st.working_hour = r_wh;
  assign st.working_min  = r_wm;
  assign st.working_sec  = r_ws;
  assign st.pkt_valid    = r_valid;
  assign st.pkt_err      = r_perr;
  assign st.frame_err    = byte_ferr;
  assign st.byte_state   = byte_st;
  assign st.pkt_state    = pkt_st;

endmodule

// File: tb/tb_uart_rx_status.sv
// Directed bench for uart_rx_status with a short bit period.
module tb_uart_rx_status;
  import uart_status_pkg::*;

  localparam int CLK_FREQ  = 320;
  localparam int BAUD_RATE = 10;
  localparam int DIV       = CLK_FREQ / BAUD_RATE;
  // rx fall -> 2 sync flops + IDLE exit (3), half start bit, 8 data bits,
  // half-to-half into stop (DIV), byte_valid -> pkt_valid (1).
  localparam int LAT = 3 + DIV / 2 + 8 * DIV + DIV + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;

  uart_rx_status_if st();

  uart_rx_status #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .st    (st)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_perr = 0;
  int n_ferr = 0;
  int last_valid_cyc = 0;
  int t_byte = 0;
  logic [38:0] exp_q[$];
  logic [38:0] got_f;

  assign got_f = {st.state, st.current_hour, st.current_min, st.current_sec,
                  st.working_hour, st.working_min, st.working_sec};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [38:0] got, input logic [38:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [38:0] pk(input logic [2:0] s, input logic [5:0] ch, cm, cs,
                                     input logic [5:0] wh, wm, ws);
    return {s, ch, cm, cs, wh, wm, ws};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (st.pkt_err)   n_perr++;
    if (st.frame_err) n_ferr++;
    if (st.pkt_valid) begin
      n_valid++;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) check_val("unexpected_pkt", 39'd1, 39'd0);
      else check_val("pkt_fields", got_f, exp_q.pop_front());
    end
  end

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk); #1;
    rx = 1'b0;
    t_byte = cyc;
    repeat (DIV) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
    rx = stop;
    repeat (DIV) @(posedge clk);
    #1;
    rx = 1'b1;
  endtask

  task automatic send_pkt(input logic [63:0] p);
    for (int i = 0; i < 8; i++) send_byte(p[63 - 8 * i -: 8], 1'b1);
  endtask

  task automatic idle_bits(input int n);
    repeat (n * DIV) @(posedge clk);
  endtask

  localparam logic [38:0] NOM  = 39'h0; // all fields zero after reset

  int bv, bp, bf;
  logic [38:0] e_nom, e_b, e_rs, e_rst, e_rng;

  // ---------------- stimulus ----------------
  initial begin
    e_nom = pk(3'd5, 6'd12, 6'd30, 6'd45, 6'd1, 6'd2, 6'd3);
    e_b   = pk(3'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7);
    e_rs  = pk(3'd7, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6);
    e_rst = pk(3'd3, 6'd23, 6'd0, 6'd59, 6'd23, 6'd59, 6'd59);
    e_rng = pk(3'd0, 6'd24, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_fields", got_f, NOM);
    check_val("reset_pulses", {st.pkt_valid, st.pkt_err, st.frame_err}, 39'd0);
    check_val("reset_byte_st", st.byte_state, BYTE_IDLE);
    check_val("reset_pkt_st", st.pkt_state, PKT_HUNT);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_bits(2);

    // nominal packet, back-to-back bytes
    bv = n_valid; bp = n_perr;
    exp_q.push_back(e_nom);
    send_pkt(64'hFF05_0C1E_2D01_0203);
    idle_bits(1);
    check_val("nom_valid_cnt", n_valid - bv, 39'd1);
    check_val("nom_perr_cnt", n_perr - bp, 39'd0);
    check_val("nom_fields", got_f, e_nom);
    check_val("nom_latency", last_valid_cyc - t_byte, LAT);

    // short glitch on an idle line
    bv = n_valid; bp = n_perr; bf = n_ferr;
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (DIV / 4) @(posedge clk);
    #1;
    rx = 1'b1;
    idle_bits(3);
    @(negedge clk);
    check_val("glitch_ferr", n_ferr - bf, 39'd0);
    check_val("glitch_perr", n_perr - bp, 39'd0);
    check_val("glitch_valid", n_valid - bv, 39'd0);
    check_val("glitch_byte_st", st.byte_state, BYTE_IDLE);
    check_val("glitch_pkt_st", st.pkt_state, PKT_HUNT);

    // bad stop bit mid-packet, then a good packet
    bv = n_valid; bp = n_perr; bf = n_ferr;
    send_byte(8'hFF, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h0C, 1'b0);
    idle_bits(3);
    check_val("badstop_ferr", n_ferr - bf, 39'd1);
    check_val("badstop_perr", n_perr - bp, 39'd1);
    check_val("badstop_valid", n_valid - bv, 39'd0);
    check_val("badstop_hold", got_f, e_nom);
    check_val("badstop_pkt_st", st.pkt_state, PKT_HUNT);
    bv = n_valid;
    exp_q.push_back(e_b);
    send_pkt(64'hFF01_0203_0405_0607);
    idle_bits(1);
    check_val("after_bad_valid", n_valid - bv, 39'd1);
    check_val("after_bad_fields", got_f, e_b);

    // resync on a sync byte inside a packet
    bv = n_valid; bp = n_perr;
    exp_q.push_back(e_rs);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h0C, 1'b1);
    send_pkt(64'hFF07_0102_0304_0506);
    idle_bits(1);
    check_val("resync_perr", n_perr - bp, 39'd1);
    check_val("resync_valid", n_valid - bv, 39'd1);
    check_val("resync_fields", got_f, e_rs);

    // reset in the middle of a packet
    send_byte(8'hFF, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h0C, 1'b1);
    send_byte(8'h1E, 1'b1);
    bv = n_valid; bp = n_perr; bf = n_ferr;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_val("rst_mid_fields", got_f, 39'd0);
    check_val("rst_mid_pkt_st", st.pkt_state, PKT_HUNT);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_bits(1);
    check_val("rst_mid_pulses", (n_valid - bv) + (n_perr - bp) + (n_ferr - bf), 39'd0);
    bv = n_valid;
    exp_q.push_back(e_rst);
    send_pkt(64'hFF03_1700_3B17_3B3B);
    idle_bits(1);
    check_val("rst_next_valid", n_valid - bv, 39'd1);
    check_val("rst_next_fields", got_f, e_rst);

    // nonzero unused upper bits abandon the packet
    bv = n_valid; bp = n_perr;
    send_byte(8'hFF, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h0C, 1'b1);
    send_byte(8'h40, 1'b1);
    idle_bits(1);
    check_val("upper_perr", n_perr - bp, 39'd1);
    check_val("upper_valid", n_valid - bv, 39'd0);
    check_val("upper_pkt_st", st.pkt_state, PKT_HUNT);
    check_val("upper_hold", got_f, e_rst);

    // hour = 24
    bv = n_valid; bp = n_perr;
`ifdef STATUS_RANGE_CHECK_EN
    send_pkt(64'hFF00_1800_0000_0000);
    idle_bits(1);
    check_val("range_perr", n_perr - bp, 39'd1);
    check_val("range_valid", n_valid - bv, 39'd0);
    check_val("range_hold", got_f, e_rst);
`else
    exp_q.push_back(e_rng);
    send_pkt(64'hFF00_1800_0000_0000);
    idle_bits(1);
    check_val("norange_perr", n_perr - bp, 39'd0);
    check_val("norange_valid", n_valid - bv, 39'd1);
    check_val("norange_fields", got_f, e_rng);
`endif

    check_val("exp_q_empty", exp_q.size(), 39'd0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #5_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
